// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Consumes a framed byte stream (MAGIC, LEN_HI, LEN_LO, 4*N payload bytes
// and an optional checksum). It packs the payload into big-endian 32-bit
// words and writes them through RAM port A to consecutive word addresses
// starting at BOOT_ADDR. The core is held in reset (cpu_rst) until a
// complete image has been accepted.
//
// Optional feature: define IMEM_LOADER_CSUM_EN to make each frame end with
// an XOR checksum byte. A checksum mismatch rejects the frame (ERROR).
// Without the macro there is no CSUM state and no checksum register.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// The upstream holds rx_data stable while rx_valid is high and rx_ready is
// low. rx_ready depends only on the loader state and on rst, never on
// rx_valid.
module imem_loader #(
  parameter int          ADDR_WIDTH = 9,
  parameter int          WORD_WIDTH = 32,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [WORD_WIDTH-1:0] ram_wdata_a,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  // Largest legal word count: the whole RAM (2^ADDR_WIDTH words).
  localparam logic [16:0]           MAX_WORDS = 17'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BOOT_WA   = BOOT_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
`ifdef IMEM_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

  // State after the last payload word (or after an empty image).
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t ST_END = ST_CSUM;
`else
  localparam state_t ST_END = ST_DONE;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [15:0]             rem_q, rem_d;
  logic [7:0]              len_hi_q, len_hi_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic        rx_fire;
  logic [15:0] len_word;

  assign rx_fire  = rx_valid && rx_ready;
  assign len_word = {len_hi_q, rx_data};

  // Output decode: everything is a function of the registered state, with
  // rst forcing the handshake and the write strobe low in the cycle it is
  // sampled so an aborted frame never issues a partial-word write.
  always_comb begin
    rx_ready    = !rst && (state_q != ST_WRITE);
    ram_we_a    = !rst && (state_q == ST_WRITE);
    ram_addr_a  = addr_q;
    ram_wdata_a = word_q;
    cpu_rst     = rst || (state_q != ST_DONE);
    done        = !rst && (state_q == ST_DONE);
    error       = !rst && (state_q == ST_ERROR);
  end

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    rem_d      = rem_q;
    len_hi_d   = len_hi_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      // Idle and both terminal states discard bytes until a frame start.
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (rx_fire && (rx_data == MAGIC)) begin
          state_d    = ST_LEN_HI;
          addr_d     = BOOT_WA;
          byte_idx_d = 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end

      ST_LEN_HI: begin
        if (rx_fire) begin
          len_hi_d = rx_data;
          state_d  = ST_LEN_LO;
        end
      end

      // The full word count is known once the low byte arrives.
      ST_LEN_LO: begin
        if (rx_fire) begin
          rem_d = len_word;
          if ({1'b0, len_word} > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else if (len_word == 16'd0) begin
            state_d = ST_END;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      // Payload bytes arrive MSB first; the fourth byte completes a word.
      ST_DATA: begin
        if (rx_fire) begin
          word_d = {word_q[WORD_WIDTH-9:0], rx_data};
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            state_d    = ST_WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      // Single write cycle; the address wraps naturally at the RAM depth.
      ST_WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        rem_d  = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = ST_END;
        end else begin
          state_d = ST_DATA;
        end
      end

`ifdef IMEM_LOADER_CSUM_EN
      // Trailing checksum must equal the XOR of every payload byte.
      ST_CSUM: begin
        if (rx_fire) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= BOOT_WA;
      word_q     <= '0;
      byte_idx_q <= 2'd0;
      rem_q      <= 16'd0;
      len_hi_q   <= 8'h00;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      rem_q      <= rem_d;
      len_hi_q   <= len_hi_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// Works with and without IMEM_LOADER_CSUM_EN; checksum bytes are only sent
// when the macro is defined.
module tb_imem_loader;

  localparam int AW = 9;
  localparam int WW = 32;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [WW-1:0] ram_wdata_a;
  logic          cpu_rst;
  logic          done;
  logic          error;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .BOOT_ADDR (32'h0000_0000),
    .MAGIC     (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_wdata_a(ram_wdata_a),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected and observed writes as {addr, data}
  logic [AW+WW-1:0] exp_q[$];
  logic [AW+WW-1:0] got_q[$];
  int acc_cnt   = 0;
  int rdy_viol  = 0;

  // Monitor on the falling edge: log writes, accepted bytes, and any cycle
  // where rx_ready and ram_we_a are not exact complements outside reset.
  always @(negedge clk) begin
    if (ram_we_a) got_q.push_back({ram_addr_a, ram_wdata_a});
    if (rx_valid && rx_ready) acc_cnt++;
    if (!rst && (ram_we_a == rx_ready)) rdy_viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Driver: present a byte and return just after the edge that accepts it.
  // rx_valid is left high so consecutive calls stream back-to-back.
  task automatic send_byte(input logic [7:0] b);
    int tries;
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    while (!rx_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!rx_ready) check("rx_ready_wait", rx_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Called right after the last payload byte (or after LEN_LO for N=0):
  // sends the checksum when enabled, otherwise lets the WRITE cycle pass.
  task automatic finish_frame(input logic [7:0] cs, input bit had_words);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(cs);
    idle();
`else
    idle();
    if (had_words) begin
      @(posedge clk);
      #1;
    end
    if (cs == 8'hFF) $display("note: unused checksum %0h", cs);
`endif
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_word"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  logic [7:0]  cs;
  logic [31:0] w;

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_we", ram_we_a, 1'b0);
    check("rst_addr", ram_addr_a, 9'd0);
    check("rst_wdata", ram_wdata_a, 32'h0);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rx_ready", rx_ready, 1'b1);
    got_q.delete();

    // Frame 1: two words, rx_valid held high through the whole frame
    acc_cnt  = 0;
    rdy_viol = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(32'h1234_5678);
    check("w0_we", ram_we_a, 1'b1);
    check("w0_ready", rx_ready, 1'b0);
    check("w0_addr", ram_addr_a, 9'd0);
    check("w0_data", ram_wdata_a, 32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    check("w1_we", ram_we_a, 1'b1);
    check("w1_addr", ram_addr_a, 9'd1);
    check("w1_data", ram_wdata_a, 32'hDEAD_BEEF);
    check("w1_done_early", done, 1'b0);
    check("w1_cpu_rst_early", cpu_rst, 1'b1);
    // XOR of 12 34 56 78 DE AD BE EF
    finish_frame(8'h2A, 1'b1);
    check("f1_done", done, 1'b1);
    check("f1_cpu_rst", cpu_rst, 1'b0);
    check("f1_error", error, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    check("f1_bytes", acc_cnt, 12);
`else
    check("f1_bytes", acc_cnt, 11);
`endif
    check("f1_ready_vs_we", rdy_viol, 0);
    exp_q.push_back({9'd0, 32'h1234_5678});
    exp_q.push_back({9'd1, 32'hDEAD_BEEF});
    check_writes("f1");

`ifdef IMEM_LOADER_CSUM_EN
    // Same frame, wrong checksum: words still land, frame rejected
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    finish_frame(8'h00, 1'b1);
    check("badcs_error", error, 1'b1);
    check("badcs_cpu_rst", cpu_rst, 1'b1);
    check("badcs_done", done, 1'b0);
    exp_q.push_back({9'd0, 32'h1234_5678});
    exp_q.push_back({9'd1, 32'hDEAD_BEEF});
    check_writes("badcs");
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h0BAD_F00D);
    finish_frame(8'h0B ^ 8'hAD ^ 8'hF0 ^ 8'h0D, 1'b1);
    check("recover_done", done, 1'b1);
    check("recover_error", error, 1'b0);
    exp_q.push_back({9'd0, 32'h0BAD_F00D});
    check_writes("recover");
`endif

    // Oversize: N = 513 > 512
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    idle();
    check("big_error", error, 1'b1);
    check("big_done", done, 1'b0);
    check("big_cpu_rst", cpu_rst, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_writes("big");

    // Leading garbage (discarded from ERROR), then a valid frame
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle();
    check("garbage_error_held", error, 1'b1);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    check("garbage_error_cleared", error, 1'b0);
    send_word(32'hCAFE_BABE);
    finish_frame(8'h30, 1'b1);
    check("garbage_done", done, 1'b1);
    check("garbage_cpu_rst", cpu_rst, 1'b0);
    exp_q.push_back({9'd0, 32'hCAFE_BABE});
    check_writes("garbage");

    // Full RAM: N = 512, last write at 511, address wraps back to 0
    rdy_viol = 0;
    cs = 8'h00;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 512; i++) begin
      w = {16'hC0DE, 16'(i)};
      exp_q.push_back({9'(i), w});
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_word(w);
    end
    finish_frame(cs, 1'b1);
    check("full_done", done, 1'b1);
    check("full_addr_wrap", ram_addr_a, 9'd0);
    check("full_ready_vs_we", rdy_viol, 0);
    check_writes("full");

    // rst after two payload bytes: abort, no write
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    idle();
    rst = 1'b1;
    #1;
    check("midrst_ready", rx_ready, 1'b0);
    check("midrst_cpu_rst", cpu_rst, 1'b1);
    @(posedge clk);
    #1;
    check("midrst_we", ram_we_a, 1'b0);
    check("midrst_addr", ram_addr_a, 9'd0);
    check("midrst_wdata", ram_wdata_a, 32'h0);
    check("midrst_done", done, 1'b0);
    check("midrst_error", error, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_writes("midrst");

    // rst arriving in the WRITE cycle suppresses the strobe
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h1122_3344);
    idle();
    rst = 1'b1;
    #1;
    check("wrrst_we", ram_we_a, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("wrrst_cpu_rst", cpu_rst, 1'b1);
    check_writes("wrrst");

    // Empty image: N = 0
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    finish_frame(8'h00, 1'b0);
    check("empty_done", done, 1'b1);
    check("empty_cpu_rst", cpu_rst, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_writes("empty");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
